load_store_queue: RTL and testbench
===================================

Name: load_store_queue

Overview:
- In-order memory-operation queue between the decoder/dispatch stage and the data-memory port, alongside the ro_buffer.
- Holds loads and stores in program order and snoops the CDB for base and store-data operands.
- Loads issue from the queue head as soon as their address is ready.
- Stores issue only when they are also at the ROB head; completion is reported to the ROB via rob_store_complete.
- Load results go out on a dedicated CDB-source port.

Parameters:
LSQ_ENTRIES, 8, queue depth (power of 2, >=2)
TAG_W, 3, ROB tag width ($clog2 of ROB entries); tag 0 = "value ready / no producer"
NUM_CDB, 4, number of CDB broadcast slots snooped

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset)
flush  in  1  sync squash of all queued entries
enq_valid  in  1  enqueue request from decoder
enq_is_store  in  1  1 = store, 0 = load
enq_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
enq_rob_tag  in  TAG_W  ROB tag of this instruction
enq_base_tag  in  TAG_W  producer tag of rs1; 0 = enq_base_value valid
enq_base_value  in  32  rs1 value
enq_data_tag  in  TAG_W  producer tag of rs2 (stores); 0 = ready
enq_data_value  in  32  rs2 value
enq_imm  in  32  sign-extended offset
full  out  1  count == LSQ_ENTRIES
empty  out  1  count == 0
cdb_valid  in  NUM_CDB  per-slot broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  per-slot tag (slot i at [i*TAG_W +: TAG_W])
cdb_value  in  NUM_CDB*32  per-slot value
rob_head_tag  in  TAG_W  tag at ROB head
rob_curr_is_store  in  1  ROB head is a store
rob_store_complete  out  1  1-cycle pulse: head store finished in memory
ld_valid  out  1  1-cycle pulse: load result valid
ld_tag  out  TAG_W  ROB tag of completed load
ld_value  out  32  extended load data
data_read  out  1  memory read request
data_write  out  1  memory write request
data_mbe  out  4  byte enables
data_addr  out  32  word-aligned address ({addr[31:2],2'b00})
data_wdata  out  32  lane-shifted store data
data_rdata  in  32  read data
data_resp  in  1  memory handshake complete

Behaviour:
- Storage: circular buffer with head_ptr, tail_ptr and count ((log2 LSQ_ENTRIES)+1 bits); pointers wrap LSQ_ENTRIES-1 -> 0.
- Reset (rst=0, async):
  - all entries invalid; pointers and count = 0; FSM = IDLE.
  - every output 0, except empty=1.
- Enqueue:
  - Accepted when enq_valid && !full, or when full and a dequeue occurs the same cycle.
  - Enqueue while full with no dequeue is dropped.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- CDB snoop, every cycle, for all valid entries:
  - For any slot with cdb_valid[i] and cdb_tag == a nonzero waiting base/data tag, capture the value and set that tag to 0.
  - The same match applies to the entry being enqueued that cycle (bypass).
  - Tag 0 on the CDB is never matched.
- Address: base_value + imm, modulo 2^32.
- data_mbe by funct3 and addr[1:0]:
  - byte: 1<<addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}; addr[0] ignored, misaligned accesses unsupported
  - word: 4'b1111
- data_wdata: rs2 replicated or shifted into the enabled lanes.
- Load extraction: selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes through.
- FSM IDLE:
  - A load issues when the head is valid and base ready.
  - A store issues when base and data are ready, entry tag == rob_head_tag, and rob_curr_is_store=1.
  - On issue, go to MEM_WAIT.
  - Request outputs are registered: asserted the cycle after the condition is seen.
- FSM MEM_WAIT:
  - data_read/data_write, addr, mbe and wdata are held stable until data_resp.
  - On data_resp, dequeue the head and return to IDLE.
  - For a load, the next cycle gives ld_valid=1, ld_tag, ld_value.
  - For a store, the next cycle gives rob_store_complete=1.
  - Request lines deassert the cycle after data_resp.
  - Back-to-back: the next head may issue the cycle after returning to IDLE.
- Flush:
  - All entries invalidated; pointers and count cleared.
  - If in MEM_WAIT, move to FLUSH_WAIT: keep the request asserted until data_resp, then go to IDLE with no ld_valid/rob_store_complete pulse.
  - In IDLE, flush takes effect immediately; an enqueue in the same cycle as flush is dropped.
- Data-dependent outputs (ld_tag, ld_value, data_addr, data_mbe, data_wdata) hold their last value when their valid/request is low; no X.

Test Plan:
- LW, base ready (0x100), imm 4, rdata 0xDEADBEEF with 1-cycle resp -> data_read=1, data_addr=0x104, mbe=1111; ld_valid pulse with ld_value=0xDEADBEEF, tag echoed.
- LB at addr 0x103 with rdata 0x80xxxxxx -> mbe=1000, ld_value=0xFFFFFF80; same with LBU -> 0x00000080.
- SH, data tag=5 pending; CDB slot 2 broadcasts tag 5 value 0x1234; rob_head_tag matches and rob_curr_is_store=1 -> mbe=1100 at addr[1]=1, wdata[31:16]=0x1234, rob_store_complete single pulse after data_resp.
- Store at LSQ head with rob_head_tag mismatched for 10 cycles -> no data_write; write issues the cycle after the tags match.
- Enqueue 8 entries -> full=1, 9th dropped; dequeue and enqueue in the same cycle -> count stays 8; wrap-around entries complete in order.
- Flush during MEM_WAIT of a load, data_resp 3 cycles later -> data_read held until resp, no ld_valid, empty=1; async rst=0 mid-transaction -> all outputs 0 immediately.

Source files
------------

// File: rtl/load_store_queue.sv
// In-order load/store queue: CDB operand snoop, head-only issue,
// registered data-memory port, load result return to the CDB.
module load_store_queue #(
    parameter int LSQ_ENTRIES = 8,
    parameter int TAG_W       = 3,
    parameter int NUM_CDB     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic                     enq_is_store,
    input  logic [2:0]               enq_funct3,
    input  logic [TAG_W-1:0]         enq_rob_tag,
    input  logic [TAG_W-1:0]         enq_base_tag,
    input  logic [31:0]              enq_base_value,
    input  logic [TAG_W-1:0]         enq_data_tag,
    input  logic [31:0]              enq_data_value,
    input  logic [31:0]              enq_imm,
    output logic                     full,
    output logic                     empty,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]    cdb_value,
    input  logic [TAG_W-1:0]         rob_head_tag,
    input  logic                     rob_curr_is_store,
    output logic                     rob_store_complete,
    output logic                     ld_valid,
    output logic [TAG_W-1:0]         ld_tag,
    output logic [31:0]              ld_value,
    output logic                     data_read,
    output logic                     data_write,
    output logic [3:0]               data_mbe,
    output logic [31:0]              data_addr,
    output logic [31:0]              data_wdata,
    input  logic [31:0]              data_rdata,
    input  logic                     data_resp
);
    localparam int PW = $clog2(LSQ_ENTRIES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, FLUSH_WAIT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             v_q    [LSQ_ENTRIES];
    logic             st_q   [LSQ_ENTRIES];
    logic [2:0]       f3_q   [LSQ_ENTRIES];
    logic [TAG_W-1:0] rt_q   [LSQ_ENTRIES];
    logic [TAG_W-1:0] bt_q   [LSQ_ENTRIES];
    logic [31:0]      bv_q   [LSQ_ENTRIES];
    logic [TAG_W-1:0] dt_q   [LSQ_ENTRIES];
    logic [31:0]      dv_q   [LSQ_ENTRIES];
    logic [31:0]      imm_q  [LSQ_ENTRIES];

    logic             rd_q, wr_q, rsc_q, ldv_q, req_st_q;
    logic [3:0]       mbe_q;
    logic [31:0]      addr_q, wdata_q, ldval_q;
    logic [TAG_W-1:0] ldtag_q, req_tag_q;
    logic [2:0]       req_f3_q;
    logic [1:0]       req_off_q;

    logic             issue, deq, accept;
    logic [31:0]      hd_addr;

    function automatic logic [TAG_W+31:0] snoop(input logic [TAG_W-1:0] t,
                                                input logic [31:0] v);
        logic [TAG_W-1:0] rt;
        logic [31:0]      rv;
        rt = t;
        rv = v;
        for (int s = 0; s < NUM_CDB; s++) begin
            if (cdb_valid[s] && t != '0 && cdb_tag[s*TAG_W +: TAG_W] == t) begin
                rt = '0;
                rv = cdb_value[s*32 +: 32];
            end
        end
        return {rt, rv};
    endfunction

    function automatic logic [3:0] mbe_of(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] sb, sh;
        sb = rd >> {off, 3'b000};
        sh = rd >> {off[1], 4'b0000};
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, sb[7:0]} : {{24{sb[7]}}, sb[7:0]};
            2'b01:   return f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    assign full    = (count_q == CW'(LSQ_ENTRIES));
    assign empty   = (count_q == '0);
    assign hd_addr = bv_q[head_q] + imm_q[head_q];

    assign issue = (state_q == IDLE) && !flush && v_q[head_q] && (bt_q[head_q] == '0)
                && (!st_q[head_q] || ((dt_q[head_q] == '0)
                && (rt_q[head_q] == rob_head_tag) && rob_curr_is_store));
    assign deq    = (state_q == MEM_WAIT) && data_resp && !flush;
    assign accept = enq_valid && !flush && (!full || deq);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (issue) state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (data_resp)  state_d = IDLE;
                else if (flush) state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: if (data_resp) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        head_d  = flush ? '0 : head_q + PW'(deq);
        tail_d  = flush ? '0 : tail_q + PW'(accept);
        count_d = flush ? '0 : count_q + CW'(accept) - CW'(deq);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Waiting operands snoop every cycle; the enqueuing entry snoops too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LSQ_ENTRIES; i++) begin
                v_q[i]   <= 1'b0;
                st_q[i]  <= 1'b0;
                f3_q[i]  <= '0;
                rt_q[i]  <= '0;
                bt_q[i]  <= '0;
                bv_q[i]  <= '0;
                dt_q[i]  <= '0;
                dv_q[i]  <= '0;
                imm_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LSQ_ENTRIES; i++) v_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < LSQ_ENTRIES; i++) begin
                if (v_q[i]) begin
                    {bt_q[i], bv_q[i]} <= snoop(bt_q[i], bv_q[i]);
                    {dt_q[i], dv_q[i]} <= snoop(dt_q[i], dv_q[i]);
                end
            end
            if (deq) v_q[head_q] <= 1'b0;
            if (accept) begin
                v_q[tail_q]   <= 1'b1;
                st_q[tail_q]  <= enq_is_store;
                f3_q[tail_q]  <= enq_funct3;
                rt_q[tail_q]  <= enq_rob_tag;
                imm_q[tail_q] <= enq_imm;
                {bt_q[tail_q], bv_q[tail_q]} <= snoop(enq_base_tag, enq_base_value);
                {dt_q[tail_q], dv_q[tail_q]} <= snoop(enq_data_tag, enq_data_value);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rsc_q     <= 1'b0;
            ldv_q     <= 1'b0;
            mbe_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ldval_q   <= '0;
            ldtag_q   <= '0;
            req_st_q  <= 1'b0;
            req_tag_q <= '0;
            req_f3_q  <= '0;
            req_off_q <= '0;
        end else begin
            rsc_q <= 1'b0;
            ldv_q <= 1'b0;
            if (issue) begin
                rd_q      <= !st_q[head_q];
                wr_q      <= st_q[head_q];
                addr_q    <= {hd_addr[31:2], 2'b00};
                mbe_q     <= mbe_of(f3_q[head_q], hd_addr[1:0]);
                wdata_q   <= wdata_of(f3_q[head_q], dv_q[head_q]);
                req_st_q  <= st_q[head_q];
                req_tag_q <= rt_q[head_q];
                req_f3_q  <= f3_q[head_q];
                req_off_q <= hd_addr[1:0];
            end
            if (state_q != IDLE && data_resp) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
                if (deq) begin
                    if (req_st_q) begin
                        rsc_q <= 1'b1;
                    end else begin
                        ldv_q   <= 1'b1;
                        ldtag_q <= req_tag_q;
                        ldval_q <= ld_ext(req_f3_q, req_off_q, data_rdata);
                    end
                end
            end
        end
    end

    assign data_read          = rd_q;
    assign data_write         = wr_q;
    assign data_mbe           = mbe_q;
    assign data_addr          = addr_q;
    assign data_wdata         = wdata_q;
    assign rob_store_complete = rsc_q;
    assign ld_valid           = ldv_q;
    assign ld_tag             = ldtag_q;
    assign ld_value           = ldval_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: loads, stores, ROB gating,
// full/wrap, flush and async reset.
module tb_load_store_queue;
    localparam int N  = 8;
    localparam int TW = 3;
    localparam int NC = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           enq_valid, enq_is_store;
    logic [2:0]     enq_funct3;
    logic [TW-1:0]  enq_rob_tag, enq_base_tag, enq_data_tag;
    logic [31:0]    enq_base_value, enq_data_value, enq_imm;
    logic           full, empty;
    logic [NC-1:0]  cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*32-1:0] cdb_value;
    logic [TW-1:0]  rob_head_tag;
    logic           rob_curr_is_store;
    logic           rob_store_complete;
    logic           ld_valid;
    logic [TW-1:0]  ld_tag;
    logic [31:0]    ld_value;
    logic           data_read, data_write;
    logic [3:0]     data_mbe;
    logic [31:0]    data_addr, data_wdata, data_rdata;
    logic           data_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_queue #(.LSQ_ENTRIES(N), .TAG_W(TW), .NUM_CDB(NC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_is_store(enq_is_store),
        .enq_funct3(enq_funct3), .enq_rob_tag(enq_rob_tag),
        .enq_base_tag(enq_base_tag), .enq_base_value(enq_base_value),
        .enq_data_tag(enq_data_tag), .enq_data_value(enq_data_value),
        .enq_imm(enq_imm), .full(full), .empty(empty),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rob_head_tag(rob_head_tag), .rob_curr_is_store(rob_curr_is_store),
        .rob_store_complete(rob_store_complete),
        .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_value(ld_value),
        .data_read(data_read), .data_write(data_write),
        .data_mbe(data_mbe), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_resp(data_resp)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic st, input logic [2:0] f3, input logic [TW-1:0] rt,
                       input logic [TW-1:0] bt, input logic [31:0] bv,
                       input logic [TW-1:0] dt, input logic [31:0] dv,
                       input logic [31:0] imm);
        enq_valid      = 1'b1;
        enq_is_store   = st;
        enq_funct3     = f3;
        enq_rob_tag    = rt;
        enq_base_tag   = bt;
        enq_base_value = bv;
        enq_data_tag   = dt;
        enq_data_value = dv;
        enq_imm        = imm;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!(data_read || data_write) && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(data_read | data_write), 32'd1);
    endtask

    task automatic respond(input logic [31:0] rd);
        data_resp  = 1'b1;
        data_rdata = rd;
        tick();
        data_resp = 1'b0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_is_store = 1'b0;
        enq_funct3 = '0; enq_rob_tag = '0; enq_base_tag = '0; enq_data_tag = '0;
        enq_base_value = '0; enq_data_value = '0; enq_imm = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        rob_head_tag = '0; rob_curr_is_store = 1'b0;
        data_rdata = '0; data_resp = 1'b0;
        tick(); tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_read", 32'(data_read), 32'd0);
        chk("rst_write", 32'(data_write), 32'd0);
        chk("rst_ldv", 32'(ld_valid), 32'd0);
        chk("rst_rsc", 32'(rob_store_complete), 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        rst = 1'b1;
        tick();

        // LW
        enq(1'b0, 3'b010, 3'd1, 3'd0, 32'h100, 3'd0, 32'd0, 32'd4);
        wait_req("lw_req");
        chk("lw_read", 32'(data_read), 32'd1);
        chk("lw_addr", data_addr, 32'h104);
        chk("lw_mbe", 32'(data_mbe), 32'hF);
        respond(32'hDEADBEEF);
        chk("lw_ldv", 32'(ld_valid), 32'd1);
        chk("lw_val", ld_value, 32'hDEADBEEF);
        chk("lw_tag", 32'(ld_tag), 32'd1);
        chk("lw_rd_off", 32'(data_read), 32'd0);
        chk("lw_empty", 32'(empty), 32'd1);
        tick();
        chk("lw_ldv_pulse", 32'(ld_valid), 32'd0);

        // LB / LBU / LH
        enq(1'b0, 3'b000, 3'd2, 3'd0, 32'h100, 3'd0, 32'd0, 32'd3);
        wait_req("lb_req");
        chk("lb_addr", data_addr, 32'h100);
        chk("lb_mbe", 32'(data_mbe), 32'h8);
        respond(32'h80123456);
        chk("lb_val", ld_value, 32'hFFFFFF80);
        enq(1'b0, 3'b100, 3'd3, 3'd0, 32'h100, 3'd0, 32'd0, 32'd3);
        wait_req("lbu_req");
        chk("lbu_mbe", 32'(data_mbe), 32'h8);
        respond(32'h80123456);
        chk("lbu_val", ld_value, 32'h00000080);
        chk("lbu_tag", 32'(ld_tag), 32'd3);
        enq(1'b0, 3'b001, 3'd4, 3'd0, 32'h100, 3'd0, 32'd0, 32'd6);
        wait_req("lh_req");
        chk("lh_addr", data_addr, 32'h104);
        chk("lh_mbe", 32'(data_mbe), 32'hC);
        respond(32'h80011234);
        chk("lh_val", ld_value, 32'hFFFF8001);

        // SH waiting on CDB slot 2
        rob_head_tag = 3'd2;
        rob_curr_is_store = 1'b1;
        enq(1'b1, 3'b001, 3'd2, 3'd0, 32'h200, 3'd5, 32'd0, 32'd2);
        tick(); tick();
        chk("sh_wait", 32'(data_write), 32'd0);
        cdb_valid = 4'b0100;
        cdb_tag = 12'(5) << 6;
        cdb_value = 128'(32'h1234) << 64;
        tick();
        cdb_valid = '0;
        wait_req("sh_req");
        chk("sh_write", 32'(data_write), 32'd1);
        chk("sh_read", 32'(data_read), 32'd0);
        chk("sh_addr", data_addr, 32'h200);
        chk("sh_mbe", 32'(data_mbe), 32'hC);
        chk("sh_wdata", 32'(data_wdata[31:16]), 32'h1234);
        respond(32'd0);
        chk("sh_rsc", 32'(rob_store_complete), 32'd1);
        chk("sh_wr_off", 32'(data_write), 32'd0);
        chk("sh_no_ldv", 32'(ld_valid), 32'd0);
        tick();
        chk("sh_rsc_pulse", 32'(rob_store_complete), 32'd0);

        // SW gated by ROB head tag
        rob_head_tag = 3'd4;
        enq(1'b1, 3'b010, 3'd3, 3'd0, 32'h300, 3'd0, 32'hCAFEF00D, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("sw_gated", 32'(data_write), 32'd0);
            tick();
        end
        rob_head_tag = 3'd3;
        tick();
        chk("sw_write", 32'(data_write), 32'd1);
        chk("sw_addr", data_addr, 32'h300);
        chk("sw_mbe", 32'(data_mbe), 32'hF);
        chk("sw_wdata", data_wdata, 32'hCAFEF00D);
        respond(32'd0);
        chk("sw_rsc", 32'(rob_store_complete), 32'd1);
        tick();

        // Fill, drop, simultaneous enq/deq, wrap
        for (int i = 0; i < 8; i++)
            enq(1'b0, 3'b010, 3'(i), 3'd7, 32'd0, 3'd0, 32'd0, 32'(4 * i));
        chk("fill_full", 32'(full), 32'd1);
        enq(1'b0, 3'b010, 3'd6, 3'd7, 32'd0, 3'd0, 32'd0, 32'h40);
        chk("drop_full", 32'(full), 32'd1);
        chk("fill_no_req", 32'(data_read), 32'd0);
        cdb_valid = 4'b0011;
        cdb_tag = 12'(7) << 3;
        cdb_value = (128'(32'h1000) << 32) | 128'(32'hBAD0BAD0);
        tick();
        cdb_valid = '0;
        for (int k = 0; k < 9; k++) begin
            wait_req("wrap_req");
            chk("wrap_addr", data_addr, (k < 8) ? 32'(32'h1000 + 4 * k) : 32'h2080);
            if (k == 0) begin
                enq_valid = 1'b1; enq_is_store = 1'b0; enq_funct3 = 3'b010;
                enq_rob_tag = 3'd5; enq_base_tag = 3'd0;
                enq_base_value = 32'h2000; enq_imm = 32'h80;
                respond(32'hA0);
                enq_valid = 1'b0;
                chk("simul_full", 32'(full), 32'd1);
            end else begin
                respond(32'(32'hA0 + k));
            end
            chk("wrap_ldv", 32'(ld_valid), 32'd1);
            chk("wrap_tag", 32'(ld_tag), (k < 8) ? 32'(k) : 32'd5);
            chk("wrap_val", ld_value, 32'(32'hA0 + k));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        tick(); tick(); tick();
        chk("drain_idle", 32'(data_read), 32'd0);

        // Flush during MEM_WAIT
        enq(1'b0, 3'b010, 3'd2, 3'd0, 32'h400, 3'd0, 32'd0, 32'd8);
        wait_req("fl_req");
        chk("fl_addr", data_addr, 32'h408);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_hold1", 32'(data_read), 32'd1);
        chk("fl_empty", 32'(empty), 32'd1);
        tick();
        chk("fl_hold2", 32'(data_read), 32'd1);
        chk("fl_addr_hold", data_addr, 32'h408);
        tick();
        respond(32'h55);
        chk("fl_no_ldv", 32'(ld_valid), 32'd0);
        chk("fl_rd_off", 32'(data_read), 32'd0);
        tick();
        chk("fl_no_ldv2", 32'(ld_valid), 32'd0);

        // Flush in IDLE drops same-cycle enqueue
        enq_valid = 1'b1; enq_base_tag = 3'd0; enq_imm = 32'd0;
        flush = 1'b1;
        tick();
        enq_valid = 1'b0; flush = 1'b0;
        chk("fl_enq_drop", 32'(empty), 32'd1);
        tick();
        chk("fl_enq_noreq", 32'(data_read), 32'd0);

        // Async reset mid-transaction
        enq(1'b0, 3'b010, 3'd3, 3'd0, 32'h500, 3'd0, 32'd0, 32'd0);
        wait_req("ar_req");
        chk("ar_addr", data_addr, 32'h500);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_read", 32'(data_read), 32'd0);
        chk("ar_addr0", data_addr, 32'd0);
        chk("ar_mbe", 32'(data_mbe), 32'd0);
        chk("ar_ldval", ld_value, 32'd0);
        chk("ar_ldtag", 32'(ld_tag), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        #2;
        rst = 1'b1;
        tick();
        chk("ar_post_empty", 32'(empty), 32'd1);
        chk("ar_post_read", 32'(data_read), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
